// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: request, response and byte-wide RAM signals shared by the arbiter and its users
interface mem_arbiter_if #(parameter int ADDR_W = 32);
  logic if_req, if_done, ls_req, ls_we, ls_done, mem_wr, io_buffer_full;
  logic [ADDR_W-1:0] if_addr, ls_addr, mem_a;
  logic [31:0] if_data, ls_wdata, ls_rdata;
  logic [1:0] ls_size;
  logic [7:0] mem_din, mem_dout;
  modport master(
    output if_req, if_addr, ls_req, ls_we, ls_size, ls_addr, ls_wdata, mem_din, io_buffer_full,
    input if_done, if_data, ls_done, ls_rdata, mem_dout, mem_a, mem_wr
  );
  modport slave(
    input if_req, if_addr, ls_req, ls_we, ls_size, ls_addr, ls_wdata, mem_din, io_buffer_full,
    output if_done, if_data, ls_done, ls_rdata, mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin IF/LS arbiter serialising 1/2/4-byte accesses onto a byte-wide RAM port
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter logic [1:0] IO_SEL = 2'b11
) (
  input logic clk,
  input logic rst_n,
  input logic rdy_in,
  input logic clear,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RD, WR} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] addr, a_k, a_out;
  logic [31:0] wdata, dbuf, word, if_data_r, ls_rdata_r;
  logic [7:0] dout;
  logic [2:0] k, n, ls_n;
  logic pend, is_if, last, if_done_r, ls_done_r, gnt_if, gnt_ls, issue, fin, abort, wr, gi;
  // k counts addresses issued; pend marks that last cycle's address has its byte on mem_din now
  always_comb begin
    gi = bus.if_req && !clear && !if_done_r;
    gnt_ls = bus.ls_req && !ls_done_r && (!gi || !last);
    gnt_if = gi && !gnt_ls;
    ls_n = bus.ls_size == 2'd0 ? 3'd1 : bus.ls_size == 2'd1 ? 3'd2 : 3'd4;
    a_k = addr + ADDR_W'(k);
    issue = state == WR || (state == RD && k < n);
    fin = state == RD && pend && k == n;
    abort = state == RD && is_if && clear;
    wr = state == WR && rdy_in && !(a_k[17:16] == IO_SEL && bus.io_buffer_full);
    a_out = (state == RD && !rdy_in && pend) ? a_k - ADDR_W'(1) : issue ? a_k : '0;
    dout = state == WR ? 8'(wdata >> {k[1:0], 3'b000}) : 8'd0;
    word = dbuf | (32'(bus.mem_din) << {k[1:0] - 2'd1, 3'b000});
    state_nx = state;
    case (state)
      IDLE: state_nx = gnt_ls ? (bus.ls_we ? WR : RD) : gnt_if ? RD : IDLE;
      RD: state_nx = (abort || fin) ? IDLE : RD;
      WR: state_nx = (wr && k == n - 3'd1) ? IDLE : WR;
      default: state_nx = IDLE;
    endcase
    if (!rdy_in) state_nx = state;
  end
  always_ff @(posedge clk) state <= !rst_n ? IDLE : state_nx;
  always_ff @(posedge clk)
    if (!rst_n) begin
      addr <= '0;
      wdata <= '0;
      dbuf <= '0;
      k <= '0;
      n <= '0;
      pend <= 1'b0;
      is_if <= 1'b0;
      last <= 1'b0;
      if_done_r <= 1'b0;
      ls_done_r <= 1'b0;
      if_data_r <= '0;
      ls_rdata_r <= '0;
    end else if (rdy_in) begin
      if_done_r <= fin && is_if && !abort;
      ls_done_r <= (fin && !is_if) || (wr && k == n - 3'd1);
      if (state == IDLE && (gnt_if || gnt_ls)) begin
        addr <= gnt_ls ? bus.ls_addr : bus.if_addr;
        wdata <= bus.ls_wdata;
        n <= gnt_ls ? ls_n : 3'd4;
        k <= '0;
        pend <= 1'b0;
        dbuf <= '0;
        is_if <= gnt_if;
        last <= gnt_ls;
      end
      if (state == RD) begin
        pend <= k < n;
        k <= k < n ? k + 3'd1 : k;
        if (pend) dbuf <= word;
      end
      if (wr) k <= k + 3'd1;
      if (fin && is_if && !abort) if_data_r <= word;
      if (fin && !is_if) ls_rdata_r <= word;
    end
  // done pulses are masked while frozen so each one is seen for exactly one live cycle
  assign bus.if_done = if_done_r && rdy_in;
  assign bus.ls_done = ls_done_r && rdy_in;
  assign bus.if_data = if_data_r;
  assign bus.ls_rdata = ls_rdata_r;
  assign bus.mem_a = a_out;
  assign bus.mem_wr = wr;
  assign bus.mem_dout = dout;
endmodule
